jtag_tap_responder: RTL and testbench
=====================================

# jtag_tap_responder

Single-clock IEEE 1149.1 TAP responder: the device side of the JTAG link that the L2 test benches drive. It oversamples TCK/TMS/TDI/TRSTn in the `clk_i` domain and implements the 16-state TAP, a 5-bit IR, and the IDCODE, BYPASS, CONFREG and MEMACC data registers. MEMACC turns a shifted word into one 32-bit access on a PULP-style req/gnt/rvalid memory port. It sits between the chip JTAG pads and the L2 interconnect, replacing the TCK-clocked TAP where a single clock domain is required.

## Interface
- `IDCODE_VALUE`, 32'h2495_11C3: value captured by IDCODE; bit 0 must be 1.
- `SYNC_STAGES`, 2: synchronizer depth for all JTAG inputs; minimum 2.
- `clk_i`  in  1: system clock; all state is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `jtag_tck_i`, `jtag_tms_i`, `jtag_tdi_i`, `jtag_trst_ni`  in  1 each: asynchronous JTAG pins.
- `jtag_tdo_o`  out  1: TDO. Reset value 0.
- `conf_reg_o`  out  9: CONFREG contents. Reset value 9'h000.
- `mem_req_o`  out  1, `mem_we_o`  out  1, `mem_addr_o`  out  32, `mem_wdata_o`  out  32, `mem_be_o`  out  4: memory request. Reset value 0 for all; `mem_be_o` is 4'hF whenever `mem_req_o` is high.
- `mem_gnt_i`  in  1, `mem_rvalid_i`  in  1, `mem_rdata_i`  in  32: grant, response valid, read data.

## Operation
- **Input synchronization.** TCK, TMS, TDI and TRSTn each pass through `SYNC_STAGES` flops. A rising or falling TCK edge is detected from the last synced stage and its predecessor. TMS and TDI are taken from the same synced stage, so they stay aligned with TCK.
- **TAP FSM.** The FSM advances only on a detected TCK rise, using synced TMS, and follows the 16 standard states (TLR, RTI, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR).
  - Synced TRSTn low forces TLR immediately, regardless of TCK.
  - In TLR: IR = IDCODE and the DR shift register is cleared. CONFREG and any memory access in flight are not affected.
- **IR.** 5 bits. Capture-IR loads 5'b00101. Shift-IR shifts TDI in at the MSB, LSB first. Update-IR latches the value.
  - IDCODE = 5'h01, CONFREG = 5'h06, MEMACC = 5'h08, BYPASS = 5'h1F.
  - Any other opcode selects BYPASS.
- **DR capture values** (all shift LSB first, TDI in at the MSB):
  - IDCODE: 32-bit, captures `IDCODE_VALUE`.
  - BYPASS: 1-bit, captures 0.
  - CONFREG: 9-bit, captures `conf_reg_o`. Update-DR writes `conf_reg_o`.
  - MEMACC: 65-bit, laid out as {bit64 `we`, bits63:32 `addr`, bits31:0 `data`}. Capture loads {busy, last address, last read data}.
- **TDO.** Updated on a detected TCK fall. In Shift-IR/Shift-DR it takes the shift register LSB; in all other states it is 0.
- **MEMACC Update-DR** launches one access when not busy. `mem_addr_o` = addr, `mem_we_o` = we, `mem_wdata_o` = data.
  - Update-DR while busy is ignored; no sticky error is recorded.
  - Word-aligned only: `addr[1:0]` is driven through unchanged and is not checked.
- **Memory FSM** states: IDLE → REQ (`mem_req_o`=1, held with stable address/data until `mem_gnt_i`) → RESP (wait for `mem_rvalid_i`) → IDLE.
  - busy = (state != IDLE).
  - On rvalid: for reads, latch `mem_rdata_i` into the read-data register; for writes, leave it unchanged. In both cases latch the last address.
  - Same-cycle gnt and rvalid is not allowed by the bus.

## Timing
- TCK high and low phases must each be at least `SYNC_STAGES`+2 `clk_i` periods.
- Detection latency is `SYNC_STAGES`+1 `clk_i` cycles from a pin edge to the FSM/TDO update.
- TDO is registered and changes one `clk_i` after the internal falling-edge detect.
- `mem_req_o` rises 1 `clk_i` after the TCK rise that leaves Update-DR is detected.
- `mem_req_o` falls in the cycle after `mem_gnt_i` is sampled high.
- Response data is available to the next Capture-DR one cycle after `mem_rvalid_i`.
- `rst_n` low asynchronously clears all state: TAP → TLR, IR = IDCODE, memory FSM → IDLE, all outputs to their reset values.

## Structure
- **Package `jtag_tap_resp_pkg`** holds:
  - `tap_state_e` (16 states) and `mem_state_e`;
  - `IR_LEN` = 5 and the IR opcode constants;
  - `CONFREG_LEN` = 9 and `MEMACC_LEN` = 65.
- **Sub-module `jtag_in_sync`** holds the synchronizer chain and TCK rise/fall detection, with one instance for all four pins. The TAP FSM, IR/DR registers and memory FSM stay in the top module.

## Test plan
- After reset, shift DR without loading IR → TDO returns 32'h2495_11C3, LSB first.
- Shift IR with 5'b11111 in → TDO shows capture 5'b00101. Then shift DR with 8'hA5 → the pattern emerges delayed by 1 bit, first bit 0.
- IR = CONFREG, write 9'h002 → `conf_reg_o` = 9'h002 after Update-DR. A second shift captures 9'h002.
- IR = MEMACC, shift {1, 32'h0, 32'hABBAABBA} with `mem_gnt_i` delayed 3 cycles → one request with we=1, addr 0, wdata ABBAABBA, be F, held until gnt.
  - Then shift {0, 0, 0} with read data ABBAABBA returned → the next capture reads data = 32'hABBAABBA and busy = 0.
- Issue a MEMACC update with gnt stalled, then a second update → exactly one `mem_req_o` pulse train, and capture bit 64 = 1.
- Pull `jtag_trst_ni` low in the middle of Shift-DR → TAP reaches TLR and IR = IDCODE. `conf_reg_o` and the pending memory access are unaffected.

Source files
------------

// File: rtl/jtag_tap_resp_pkg.sv
// Shared types and constants for the single-clock JTAG TAP responder.
//   - tap_state_e : the 16 IEEE 1149.1 TAP controller states
//   - mem_state_e : memory access sequencer states
//   - dr_sel_e    : data register selected by the current instruction
//   - IR opcodes, register lengths and the IR decode helper
package jtag_tap_resp_pkg;

  localparam int IR_LEN      = 5;
  localparam int IDCODE_LEN  = 32;
  localparam int CONFREG_LEN = 9;
  localparam int MEMACC_LEN  = 65;

  localparam logic [IR_LEN-1:0] IR_IDCODE  = 5'h01;
  localparam logic [IR_LEN-1:0] IR_CONFREG = 5'h06;
  localparam logic [IR_LEN-1:0] IR_MEMACC  = 5'h08;
  localparam logic [IR_LEN-1:0] IR_BYPASS  = 5'h1F;
  // Fixed pattern loaded into the IR shift register in Capture-IR.
  localparam logic [IR_LEN-1:0] IR_CAPTURE = 5'b00101;

  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_RESP
  } mem_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_CONFREG,
    DR_MEMACC
  } dr_sel_e;

  // Unknown opcodes fall back to BYPASS.
  function automatic dr_sel_e decode_ir(input logic [IR_LEN-1:0] ir);
    dr_sel_e sel;
    case (ir)
      IR_IDCODE:  sel = DR_IDCODE;
      IR_CONFREG: sel = DR_CONFREG;
      IR_MEMACC:  sel = DR_MEMACC;
      default:    sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_responder_in_sync.sv
// Oversampling front end for the JTAG pins.
// Each pin passes through SYNC_STAGES flops (minimum 2). TCK edges are
// detected by comparing the last synchronizer stage with its value one
// clk_i earlier, so an edge pulse lasts exactly one clk_i cycle. TMS/TDI are
// taken from the same stage as TCK so they stay aligned with the edge.
// Ports:
//   clk_i, rst_n            : system clock, async active-low reset
//   tck_i/tms_i/tdi_i/trst_ni : raw asynchronous pins
//   tck_rise_o, tck_fall_o  : one-cycle TCK edge strobes
//   tms_o, tdi_o, trst_no   : synchronized pin levels
module jtag_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  input  logic trst_ni,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_o,
  output logic tdi_o,
  output logic trst_no
);

  logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q, trst_q;
  logic                   tck_last_q;

  // TRSTn resets to "asserted" so the TAP stays in TLR until the pin level
  // has propagated through the chain.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tck_q      <= '0;
      tms_q      <= '1;
      tdi_q      <= '0;
      trst_q     <= '0;
      tck_last_q <= 1'b0;
    end else begin
      tck_q      <= {tck_q[SYNC_STAGES-2:0], tck_i};
      tms_q      <= {tms_q[SYNC_STAGES-2:0], tms_i};
      tdi_q      <= {tdi_q[SYNC_STAGES-2:0], tdi_i};
      trst_q     <= {trst_q[SYNC_STAGES-2:0], trst_ni};
      tck_last_q <= tck_q[SYNC_STAGES-1];
    end
  end

  assign tck_rise_o = tck_q[SYNC_STAGES-1] & ~tck_last_q;
  assign tck_fall_o = ~tck_q[SYNC_STAGES-1] & tck_last_q;
  assign tms_o      = tms_q[SYNC_STAGES-1];
  assign tdi_o      = tdi_q[SYNC_STAGES-1];
  assign trst_no    = trst_q[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_responder.sv
// Single-clock JTAG TAP responder with IDCODE, BYPASS, CONFREG and MEMACC
// data registers. MEMACC Update-DR launches one access on a req/gnt/rvalid
// memory port.
// Ports:
//   clk_i, rst_n                 : system clock, async active-low reset
//   jtag_tck_i/tms_i/tdi_i/trst_ni : asynchronous JTAG pins
//   jtag_tdo_o                   : registered TDO, updated on TCK fall
//   conf_reg_o                   : CONFREG contents
//   mem_req_o/we_o/addr_o/wdata_o/be_o : memory request (held until gnt)
//   mem_gnt_i/rvalid_i/rdata_i   : memory grant and response
// Handshake: mem_req_o stays high with stable we/addr/wdata/be until a cycle
// where mem_gnt_i is sampled high; the response is the next mem_rvalid_i
// pulse, which never coincides with the grant.
module jtag_tap_responder
  import jtag_tap_resp_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h2495_11C3,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   jtag_tck_i,
  input  logic                   jtag_tms_i,
  input  logic                   jtag_tdi_i,
  input  logic                   jtag_trst_ni,
  output logic                   jtag_tdo_o,
  output logic [CONFREG_LEN-1:0] conf_reg_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  output logic [3:0]             mem_be_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i
);

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_s;

  jtag_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .tck_i      (jtag_tck_i),
    .tms_i      (jtag_tms_i),
    .tdi_i      (jtag_tdi_i),
    .trst_ni    (jtag_trst_ni),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s),
    .trst_no    (trst_s)
  );

  tap_state_e             tap_q, tap_d;
  mem_state_e             mem_q, mem_d;
  logic [IR_LEN-1:0]      ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [MEMACC_LEN-1:0]  dr_q, dr_d;
  logic [CONFREG_LEN-1:0] conf_q, conf_d;
  logic                   tdo_q, tdo_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]            last_addr_q, last_addr_d, rdata_q, rdata_d;
  logic                   mem_launch;
  logic                   mem_busy;
  dr_sel_e                dr_sel;

  assign dr_sel   = decode_ir(ir_q);
  assign mem_busy = (mem_q != MEM_IDLE);

  // ---------------- TAP state register ----------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) tap_q <= TAP_TLR;
    else        tap_q <= tap_d;
  end

  always_comb begin
    tap_d = tap_q;
    if (tck_rise) begin
      case (tap_q)
        TAP_TLR:      tap_d = tms_s ? TAP_TLR      : TAP_RTI;
        TAP_RTI:      tap_d = tms_s ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_DR:   tap_d = tms_s ? TAP_SEL_IR   : TAP_CAP_DR;
        TAP_CAP_DR:   tap_d = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_SHIFT_DR: tap_d = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_EXIT1_DR: tap_d = tms_s ? TAP_UPD_DR   : TAP_PAUSE_DR;
        TAP_PAUSE_DR: tap_d = tms_s ? TAP_EXIT2_DR : TAP_PAUSE_DR;
        TAP_EXIT2_DR: tap_d = tms_s ? TAP_UPD_DR   : TAP_SHIFT_DR;
        TAP_UPD_DR:   tap_d = tms_s ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_IR:   tap_d = tms_s ? TAP_TLR      : TAP_CAP_IR;
        TAP_CAP_IR:   tap_d = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_SHIFT_IR: tap_d = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_EXIT1_IR: tap_d = tms_s ? TAP_UPD_IR   : TAP_PAUSE_IR;
        TAP_PAUSE_IR: tap_d = tms_s ? TAP_EXIT2_IR : TAP_PAUSE_IR;
        TAP_EXIT2_IR: tap_d = tms_s ? TAP_UPD_IR   : TAP_SHIFT_IR;
        TAP_UPD_IR:   tap_d = tms_s ? TAP_SEL_DR   : TAP_RTI;
        default:      tap_d = TAP_TLR;
      endcase
    end
    // TRST overrides any TCK activity.
    if (!trst_s) tap_d = TAP_TLR;
  end

  // ---------------- IR / DR / TDO datapath ----------------
  // Capture/shift/update act on the TCK rise that leaves the corresponding
  // state, so an Update-DR action fires as the TAP moves on.
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    dr_d       = dr_q;
    conf_d     = conf_q;
    tdo_d      = tdo_q;
    mem_launch = 1'b0;

    if (tap_q == TAP_TLR) begin
      ir_d = IR_IDCODE;
      dr_d = '0;
    end else if (tck_rise && trst_s) begin
      case (tap_q)
        TAP_CAP_IR:   ir_shift_d = IR_CAPTURE;
        TAP_SHIFT_IR: ir_shift_d = {tdi_s, ir_shift_q[IR_LEN-1:1]};
        TAP_UPD_IR:   ir_d       = ir_shift_q;
        TAP_CAP_DR: begin
          case (dr_sel)
            DR_IDCODE:  dr_d = {{(MEMACC_LEN-IDCODE_LEN){1'b0}}, IDCODE_VALUE};
            DR_CONFREG: dr_d = {{(MEMACC_LEN-CONFREG_LEN){1'b0}}, conf_q};
            DR_MEMACC:  dr_d = {mem_busy, last_addr_q, rdata_q};
            default:    dr_d = '0;
          endcase
        end
        TAP_SHIFT_DR: begin
          // TDI enters at the MSB of the selected register's own length.
          case (dr_sel)
            DR_IDCODE:  dr_d = {{(MEMACC_LEN-IDCODE_LEN){1'b0}}, tdi_s,
                                dr_q[IDCODE_LEN-1:1]};
            DR_CONFREG: dr_d = {{(MEMACC_LEN-CONFREG_LEN){1'b0}}, tdi_s,
                                dr_q[CONFREG_LEN-1:1]};
            DR_MEMACC:  dr_d = {tdi_s, dr_q[MEMACC_LEN-1:1]};
            default:    dr_d = {{(MEMACC_LEN-1){1'b0}}, tdi_s};
          endcase
        end
        TAP_UPD_DR: begin
          if (dr_sel == DR_CONFREG) conf_d = dr_q[CONFREG_LEN-1:0];
          if (dr_sel == DR_MEMACC)  mem_launch = 1'b1;
        end
        default: ;
      endcase
    end

    if (tck_fall) begin
      if (tap_q == TAP_SHIFT_IR)      tdo_d = ir_shift_q[0];
      else if (tap_q == TAP_SHIFT_DR) tdo_d = dr_q[0];
      else                            tdo_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= IR_IDCODE;
      ir_shift_q <= '0;
      dr_q       <= '0;
      conf_q     <= '0;
      tdo_q      <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      dr_q       <= dr_d;
      conf_q     <= conf_d;
      tdo_q      <= tdo_d;
    end
  end

  // ---------------- Memory access sequencer ----------------
  // A launch while busy is dropped silently.
  always_comb begin
    mem_d       = mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_addr_d = last_addr_q;
    rdata_d     = rdata_q;
    case (mem_q)
      MEM_IDLE: begin
        if (mem_launch) begin
          we_d    = dr_q[64];
          addr_d  = dr_q[63:32];
          wdata_d = dr_q[31:0];
          mem_d   = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_gnt_i) mem_d = MEM_RESP;
      end
      MEM_RESP: begin
        if (mem_rvalid_i) begin
          if (!we_q) rdata_d = mem_rdata_i;
          last_addr_d = addr_q;
          mem_d       = MEM_IDLE;
        end
      end
      default: mem_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= MEM_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_addr_q <= '0;
      rdata_q     <= '0;
    end else begin
      mem_q       <= mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_addr_q <= last_addr_d;
      rdata_q     <= rdata_d;
    end
  end

  assign jtag_tdo_o  = tdo_q;
  assign conf_reg_o  = conf_q;
  assign mem_req_o   = (mem_q == MEM_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = (mem_q == MEM_REQ) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: JTAG driver tasks, a memory
// responder with programmable grant delay/stall, a request monitor and one
// task per scenario with inline comparisons.
module tb_jtag_tap_responder;

  logic        clk, rst_n;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n, jtag_tdo;
  logic [8:0]  conf_reg;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  // Memory responder controls
  int          gnt_delay = 0;
  logic        gnt_stall = 1'b0;
  logic [31:0] resp_data = '0;

  // Request monitor results
  int          req_count  = 0;
  int          req_cycles = 0;
  int          hold_err   = 0;
  logic        rec_we;
  logic [31:0] rec_addr, rec_wdata;
  logic [3:0]  rec_be;

  jtag_tap_responder #(
    .IDCODE_VALUE (32'h2495_11C3),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .jtag_tck_i   (jtag_tck),
    .jtag_tms_i   (jtag_tms),
    .jtag_tdi_i   (jtag_tdi),
    .jtag_trst_ni (jtag_trst_n),
    .jtag_tdo_o   (jtag_tdo),
    .conf_reg_o   (conf_reg),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        repeat (gnt_delay) @(negedge clk);
        while (gnt_stall) @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = resp_data;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  // ---------------- request monitor ----------------
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !req_prev) begin
        req_count++;
        req_cycles = 1;
        rec_we     = mem_we;
        rec_addr   = mem_addr;
        rec_wdata  = mem_wdata;
        rec_be     = mem_be;
      end else if (mem_req) begin
        req_cycles++;
        if (mem_we !== rec_we || mem_addr !== rec_addr ||
            mem_wdata !== rec_wdata || mem_be !== rec_be)
          hold_err++;
      end
      req_prev = mem_req;
    end
  end

  // ---------------- JTAG driver tasks ----------------
  // One TCK period: TMS/TDI set while TCK low, TDO sampled just before rise.
  task automatic tck_step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    jtag_tms = tms_v;
    jtag_tdi = tdi_v;
    repeat (6) @(negedge clk);
    tdo_v = jtag_tdo;
    jtag_tck = 1'b1;
    repeat (6) @(negedge clk);
    jtag_tck = 1'b0;
  endtask

  // From RTI: shift n DR bits and return to RTI via Update-DR.
  task automatic shift_dr(input int n, input logic [64:0] din, output logic [64:0] dout);
    logic t;
    dout = '0;
    tck_step(1'b1, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      tck_step((i == n - 1), din[i], t);
      dout[i] = t;
    end
    tck_step(1'b1, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
  endtask

  // From RTI: shift 5 IR bits and return to RTI via Update-IR.
  task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
    logic t;
    dout = '0;
    tck_step(1'b1, 1'b0, t);
    tck_step(1'b1, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      tck_step((i == 4), din[i], t);
      dout[i] = t;
    end
    tck_step(1'b1, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [64:0] dout;
    logic        t;
    rst_n       = 1'b0;
    jtag_tck    = 1'b0;
    jtag_tms    = 1'b1;
    jtag_tdi    = 1'b0;
    jtag_trst_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    checks++; if (jtag_tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo: got %b expected 0", jtag_tdo); end
    checks++; if (conf_reg !== 9'h000) begin failures++; $display("FAIL reset_conf: got %h expected 000", conf_reg); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_be: got %h expected 0", mem_be); end
    checks++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin failures++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_we, mem_addr, mem_wdata}); end

    tck_step(1'b0, 1'b0, t);  // TLR -> RTI
    shift_dr(32, 65'h0, dout);
    checks++; if (dout[31:0] !== 32'h2495_11C3) begin failures++; $display("FAIL reset_idcode: got %h expected 249511c3", dout[31:0]); end
  endtask

  task automatic test_ir_bypass();
    logic [4:0]  irout;
    logic [64:0] dout;
    shift_ir(5'h1F, irout);
    checks++; if (irout !== 5'b00101) begin failures++; $display("FAIL ir_capture: got %b expected 00101", irout); end
    shift_dr(9, 65'h0A5, dout);
    checks++; if (dout[8:0] !== 9'h14A) begin failures++; $display("FAIL bypass_a5: got %h expected 14a", dout[8:0]); end
    // Unknown opcode behaves as BYPASS.
    shift_ir(5'h03, irout);
    checks++; if (irout !== 5'b00101) begin failures++; $display("FAIL ir_capture2: got %b expected 00101", irout); end
    shift_dr(2, 65'h1, dout);
    checks++; if (dout[1:0] !== 2'b10) begin failures++; $display("FAIL bypass_unknown: got %b expected 10", dout[1:0]); end
  endtask

  task automatic test_confreg();
    logic [4:0]  irout;
    logic [64:0] dout;
    shift_ir(5'h06, irout);
    shift_dr(9, 65'h002, dout);
    checks++; if (dout[8:0] !== 9'h000) begin failures++; $display("FAIL conf_cap0: got %h expected 000", dout[8:0]); end
    checks++; if (conf_reg !== 9'h002) begin failures++; $display("FAIL conf_write1: got %h expected 002", conf_reg); end
    shift_dr(9, 65'h1A5, dout);
    checks++; if (dout[8:0] !== 9'h002) begin failures++; $display("FAIL conf_cap1: got %h expected 002", dout[8:0]); end
    checks++; if (conf_reg !== 9'h1A5) begin failures++; $display("FAIL conf_write2: got %h expected 1a5", conf_reg); end
  endtask

  task automatic test_mem_write_read();
    logic [4:0]  irout;
    logic [64:0] dout;
    shift_ir(5'h08, irout);
    gnt_delay = 3;
    shift_dr(65, {1'b1, 32'h0, 32'hABBA_ABBA}, dout);
    repeat (30) @(negedge clk);
    checks++; if (req_count !== 1) begin failures++; $display("FAIL wr_req_count: got %0d expected 1", req_count); end
    checks++; if ({rec_we, rec_addr, rec_wdata} !== {1'b1, 32'h0, 32'hABBA_ABBA}) begin failures++; $display("FAIL wr_fields: got %h expected %h", {rec_we, rec_addr, rec_wdata}, {1'b1, 32'h0, 32'hABBA_ABBA}); end
    checks++; if (rec_be !== 4'hF) begin failures++; $display("FAIL wr_be: got %h expected f", rec_be); end
    checks++; if (req_cycles !== 4) begin failures++; $display("FAIL wr_req_len: got %0d expected 4", req_cycles); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL wr_hold: got %0d expected 0", hold_err); end
    checks++; if ({mem_req, mem_be} !== 5'h0) begin failures++; $display("FAIL wr_idle: got %h expected 00", {mem_req, mem_be}); end

    gnt_delay = 0;
    resp_data = 32'hABBA_ABBA;
    shift_dr(65, 65'h0, dout);
    repeat (30) @(negedge clk);
    checks++; if (dout !== 65'h0) begin failures++; $display("FAIL rd_cap_after_wr: got %h expected 0", dout); end
    resp_data = 32'h1234_5678;
    shift_dr(65, {1'b0, 32'h0000_0040, 32'h0}, dout);
    repeat (30) @(negedge clk);
    checks++; if (dout !== {1'b0, 32'h0, 32'hABBA_ABBA}) begin failures++; $display("FAIL rd_cap_data: got %h expected %h", dout, {1'b0, 32'h0, 32'hABBA_ABBA}); end
    checks++; if (req_count !== 3 || rec_we !== 1'b0 || rec_addr !== 32'h40) begin failures++; $display("FAIL rd_req: got count=%0d we=%b addr=%h expected count=3 we=0 addr=40", req_count, rec_we, rec_addr); end
  endtask

  task automatic test_back_to_back();
    logic [64:0] dout;
    gnt_stall = 1'b1;
    shift_dr(65, {1'b1, 32'h0000_0200, 32'hDEAD_BEEF}, dout);
    checks++; if (dout !== {1'b0, 32'h40, 32'h1234_5678}) begin failures++; $display("FAIL b2b_cap1: got %h expected %h", dout, {1'b0, 32'h40, 32'h1234_5678}); end
    shift_dr(65, {1'b1, 32'h0000_0300, 32'h1111_1111}, dout);
    checks++; if (dout !== {1'b1, 32'h40, 32'h1234_5678}) begin failures++; $display("FAIL b2b_cap_busy: got %h expected %h", dout, {1'b1, 32'h40, 32'h1234_5678}); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_held: got req=%b addr=%h wdata=%h expected 1 200 deadbeef", mem_req, mem_addr, mem_wdata); end
    gnt_stall = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (req_count !== 4 || hold_err !== 0) begin failures++; $display("FAIL b2b_one_req: got count=%0d hold_err=%0d expected 4 0", req_count, hold_err); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_done: got %b expected 0", mem_req); end
  endtask

  task automatic test_trst();
    logic [64:0] dout;
    logic        t;
    gnt_stall = 1'b1;
    shift_dr(65, {1'b1, 32'h0000_0500, 32'h0000_0055}, dout);
    checks++; if (dout !== {1'b0, 32'h200, 32'h1234_5678}) begin failures++; $display("FAIL trst_cap: got %h expected %h", dout, {1'b0, 32'h200, 32'h1234_5678}); end
    // Enter Shift-DR and shift a few bits, then pull TRSTn.
    tck_step(1'b1, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
    tck_step(1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) tck_step(1'b0, 1'b1, t);
    jtag_trst_n = 1'b0;
    repeat (8) @(negedge clk);
    jtag_trst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (conf_reg !== 9'h1A5) begin failures++; $display("FAIL trst_conf: got %h expected 1a5", conf_reg); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500 || mem_we !== 1'b1) begin failures++; $display("FAIL trst_mem_pending: got req=%b addr=%h we=%b expected 1 500 1", mem_req, mem_addr, mem_we); end
    tck_step(1'b0, 1'b0, t);  // TLR -> RTI
    shift_dr(32, 65'h0, dout);
    checks++; if (dout[31:0] !== 32'h2495_11C3) begin failures++; $display("FAIL trst_idcode: got %h expected 249511c3", dout[31:0]); end
    gnt_stall = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (req_count !== 5 || mem_req !== 1'b0) begin failures++; $display("FAIL trst_req_done: got count=%0d req=%b expected 5 0", req_count, mem_req); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ir_bypass();
    test_confreg();
    test_mem_write_read();
    test_back_to_back();
    test_trst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
